// File: rtl/nn_pkg.sv
// Shared constants and types for the Q16.16 fully-connected MNIST classifier.
package nn_pkg;

  localparam int FRAC_BITS   = 16;
  localparam int DATA_BITS   = 32;
  localparam int BIT_GROWTH  = 8;
  localparam int PAD_DEFAULT = 20;
  localparam int N_PIXELS    = 784;

  localparam int L1_NEURONS_D = 256;
  localparam int L2_NEURONS_D = 128;
  localparam int L3_NEURONS_D = 64;
  localparam int L4_NEURONS_D = 10;

  // Last index of a zero-padded vector holding n live entries.
  function automatic int padded_last(input int n);
    return n + 2 * PAD_DEFAULT - 1;
  endfunction

  localparam int L1_WIDTH_D = padded_last(N_PIXELS);
  localparam int L2_WIDTH_D = padded_last(L1_NEURONS_D);
  localparam int L3_WIDTH_D = padded_last(L2_NEURONS_D);
  localparam int L4_WIDTH_D = padded_last(L3_NEURONS_D);

  localparam int L1_COUNTER_END_D = L1_WIDTH_D - 3;
  localparam int L2_COUNTER_END_D = L2_WIDTH_D - 3;
  localparam int L3_COUNTER_END_D = L3_WIDTH_D - 3;
  localparam int L4_COUNTER_END_D = L4_WIDTH_D - 3;

  localparam int L1_BITS_D = DATA_BITS - 1;
  localparam int L2_BITS_D = L1_BITS_D + BIT_GROWTH;
  localparam int L3_BITS_D = L2_BITS_D + BIT_GROWTH;
  localparam int L4_BITS_D = L3_BITS_D + BIT_GROWTH;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_OUT  = 2'd1,
    ST_DONE = 2'd2
  } layer_state_e;

endpackage

// File: rtl/neural_network_param_layer.sv
// One fully-connected layer: every neuron accumulates one input element per
// clock, then adds its bias (optionally ReLU) and holds the result with done.
module nn_layer
  import nn_pkg::*;
#(
  parameter int NEURONS     = 10,
  parameter int WIDTH       = 103,
  parameter int COUNTER_END = 100,
  parameter int N_IN        = 64,
  parameter int PAD         = PAD_DEFAULT,
  parameter int IN_BITS     = 47,
  parameter int OUT_BITS    = 55,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic signed [IN_BITS:0]    i_x [0:WIDTH],
  input  logic signed [DATA_BITS-1:0] i_w [0:NEURONS-1][0:WIDTH],
  input  logic signed [DATA_BITS-1:0] i_b [0:NEURONS-1],
  output logic signed [OUT_BITS:0]   o_out [0:NEURONS-1],
  output logic                       o_done
);

  localparam int IN_W   = IN_BITS + 1;
  localparam int ACC_W  = OUT_BITS + 1;
  localparam int PROD_W = IN_W + DATA_BITS;
  localparam int CNT_W  = $clog2(COUNTER_END + 2);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_END);
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(PAD + N_IN);

  layer_state_e            r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    w_in_window;
  logic                    w_acc_en;
  logic                    w_out_en;
  logic signed [IN_BITS:0] w_x_cur;

  // Pad entries are skipped even when nonzero, so only the live window adds.
  assign w_in_window = (r_cnt >= WIN_LO) && (r_cnt < WIN_HI);
  assign w_x_cur     = i_x[r_cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_en     = 1'b0;
    w_out_en     = 1'b0;
    case (r_state)
      ST_ACC: begin
        if (i_start) begin
          w_acc_en   = w_in_window;
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_next = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        w_out_en     = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_ACC;
      end
    endcase
  end

  assign o_done = (r_state == ST_DONE);

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_out;

    assign w_prod = PROD_W'(w_x_cur) * PROD_W'(i_w[gi][r_cnt]);
    // Accumulator wraps: the shifted product is truncated to the acc width.
    assign w_term = ACC_W'(w_prod >>> FRAC_BITS);
    assign w_sum  = r_acc + ACC_W'(i_b[gi]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
        r_out <= '0;
      end else begin
        if (w_acc_en) begin
          r_acc <= r_acc + w_term;
        end
        if (w_out_en) begin
          r_out <= (RELU_EN && w_sum[ACC_W-1]) ? '0 : w_sum;
        end
      end
    end

    assign o_out[gi] = r_out;
  end

endmodule

// File: rtl/neural_network_param.sv
// 784-256-128-64-10 Q16.16 classifier built from four chained nn_layer stages.
// Optional macro NN_DONE_OUT_EN adds the nn_done completion port.
module neural_network_param
  import nn_pkg::*;
#(
  parameter int L1_NEURONS     = L1_NEURONS_D,
  parameter int L1_WIDTH       = L1_WIDTH_D,
  parameter int L1_COUNTER_END = L1_COUNTER_END_D,
  parameter int L1_BITS        = L1_BITS_D,
  parameter int L2_NEURONS     = L2_NEURONS_D,
  parameter int L2_WIDTH       = L2_WIDTH_D,
  parameter int L2_COUNTER_END = L2_COUNTER_END_D,
  parameter int L2_BITS        = L2_BITS_D,
  parameter int L3_NEURONS     = L3_NEURONS_D,
  parameter int L3_WIDTH       = L3_WIDTH_D,
  parameter int L3_COUNTER_END = L3_COUNTER_END_D,
  parameter int L3_BITS        = L3_BITS_D,
  parameter int L4_NEURONS     = L4_NEURONS_D,
  parameter int L4_WIDTH       = L4_WIDTH_D,
  parameter int L4_COUNTER_END = L4_COUNTER_END_D,
  parameter int L4_BITS        = L4_BITS_D,
  parameter int PAD            = PAD_DEFAULT,
  localparam int OUTPUT_BITS   = L4_BITS + BIT_GROWTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_BITS-1:0]   data_in [0:L1_WIDTH],
  input  logic signed [DATA_BITS-1:0]   w1 [0:L1_NEURONS-1][0:L1_WIDTH],
  input  logic signed [DATA_BITS-1:0]   w2 [0:L2_NEURONS-1][0:L2_WIDTH],
  input  logic signed [DATA_BITS-1:0]   w3 [0:L3_NEURONS-1][0:L3_WIDTH],
  input  logic signed [DATA_BITS-1:0]   w4 [0:L4_NEURONS-1][0:L4_WIDTH],
  input  logic signed [DATA_BITS-1:0]   b1 [0:L1_NEURONS-1],
  input  logic signed [DATA_BITS-1:0]   b2 [0:L2_NEURONS-1],
  input  logic signed [DATA_BITS-1:0]   b3 [0:L3_NEURONS-1],
  input  logic signed [DATA_BITS-1:0]   b4 [0:L4_NEURONS-1],
  output logic signed [OUTPUT_BITS:0]   neuralnet_out [0:L4_NEURONS-1]
`ifdef NN_DONE_OUT_EN
  ,
  output logic                          nn_done
`endif
);

  localparam int OUT_W = OUTPUT_BITS + 1;

  logic layer1_done;
  logic layer2_done;
  logic layer3_done;
  logic layer4_done;

  logic signed [L1_BITS:0] w_l1_out [0:L1_NEURONS-1];
  logic signed [L2_BITS:0] w_l2_out [0:L2_NEURONS-1];
  logic signed [L3_BITS:0] w_l3_out [0:L3_NEURONS-1];
  logic signed [L4_BITS:0] w_l4_out [0:L4_NEURONS-1];

  logic signed [L1_BITS:0] w_x2 [0:L2_WIDTH];
  logic signed [L2_BITS:0] w_x3 [0:L3_WIDTH];
  logic signed [L3_BITS:0] w_x4 [0:L4_WIDTH];

  // Each downstream input vector is the previous layer's outputs framed by zeros.
  for (genvar gi = 0; gi <= L2_WIDTH; gi++) begin : g_x2
    if (gi >= PAD && gi < PAD + L1_NEURONS) begin : g_live
      assign w_x2[gi] = w_l1_out[gi-PAD];
    end else begin : g_pad
      assign w_x2[gi] = '0;
    end
  end

  for (genvar gi = 0; gi <= L3_WIDTH; gi++) begin : g_x3
    if (gi >= PAD && gi < PAD + L2_NEURONS) begin : g_live
      assign w_x3[gi] = w_l2_out[gi-PAD];
    end else begin : g_pad
      assign w_x3[gi] = '0;
    end
  end

  for (genvar gi = 0; gi <= L4_WIDTH; gi++) begin : g_x4
    if (gi >= PAD && gi < PAD + L3_NEURONS) begin : g_live
      assign w_x4[gi] = w_l3_out[gi-PAD];
    end else begin : g_pad
      assign w_x4[gi] = '0;
    end
  end

  nn_layer #(
    .NEURONS(L1_NEURONS), .WIDTH(L1_WIDTH), .COUNTER_END(L1_COUNTER_END),
    .N_IN(N_PIXELS), .PAD(PAD), .IN_BITS(DATA_BITS-1), .OUT_BITS(L1_BITS),
    .RELU_EN(1'b1)
  ) u_layer1 (
    .clk(clk), .rst(rst), .i_start(1'b1),
    .i_x(data_in), .i_w(w1), .i_b(b1),
    .o_out(w_l1_out), .o_done(layer1_done)
  );

  nn_layer #(
    .NEURONS(L2_NEURONS), .WIDTH(L2_WIDTH), .COUNTER_END(L2_COUNTER_END),
    .N_IN(L1_NEURONS), .PAD(PAD), .IN_BITS(L1_BITS), .OUT_BITS(L2_BITS),
    .RELU_EN(1'b1)
  ) u_layer2 (
    .clk(clk), .rst(rst), .i_start(layer1_done),
    .i_x(w_x2), .i_w(w2), .i_b(b2),
    .o_out(w_l2_out), .o_done(layer2_done)
  );

  nn_layer #(
    .NEURONS(L3_NEURONS), .WIDTH(L3_WIDTH), .COUNTER_END(L3_COUNTER_END),
    .N_IN(L2_NEURONS), .PAD(PAD), .IN_BITS(L2_BITS), .OUT_BITS(L3_BITS),
    .RELU_EN(1'b1)
  ) u_layer3 (
    .clk(clk), .rst(rst), .i_start(layer2_done),
    .i_x(w_x3), .i_w(w3), .i_b(b3),
    .o_out(w_l3_out), .o_done(layer3_done)
  );

  nn_layer #(
    .NEURONS(L4_NEURONS), .WIDTH(L4_WIDTH), .COUNTER_END(L4_COUNTER_END),
    .N_IN(L3_NEURONS), .PAD(PAD), .IN_BITS(L3_BITS), .OUT_BITS(L4_BITS),
    .RELU_EN(1'b0)
  ) u_layer4 (
    .clk(clk), .rst(rst), .i_start(layer3_done),
    .i_x(w_x4), .i_w(w4), .i_b(b4),
    .o_out(w_l4_out), .o_done(layer4_done)
  );

  for (genvar gi = 0; gi < L4_NEURONS; gi++) begin : g_logit
    assign neuralnet_out[gi] = OUT_W'(w_l4_out[gi]);
  end

`ifdef NN_DONE_OUT_EN
  assign nn_done = layer4_done;
`else
  // Without the port, completion is known only from the fixed latency.
  logic w_unused_done;
  assign w_unused_done = layer4_done;
`endif

endmodule

// File: tb/tb_neural_network_param.sv
// Randomised + directed bench for neural_network_param against a Q16.16 reference.
module tb_neural_network_param;

  localparam int N1 = 256, W1 = 823;
  localparam int N2 = 128, W2 = 295;
  localparam int N3 = 64,  W3 = 167;
  localparam int N4 = 10,  W4 = 103;
  localparam int PADN = 20;
  // Posedges after reset release at which each layer's done must be high.
  localparam int T1 = 822;
  localparam int T2 = T1 + 294;
  localparam int T3 = T2 + 166;
  localparam int T4 = T3 + 102;

  typedef logic signed [63:0] logit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [31:0] data_in [0:W1];
  logic signed [31:0] w1 [0:N1-1][0:W1];
  logic signed [31:0] w2 [0:N2-1][0:W2];
  logic signed [31:0] w3 [0:N3-1][0:W3];
  logic signed [31:0] w4 [0:N4-1][0:W4];
  logic signed [31:0] b1 [0:N1-1];
  logic signed [31:0] b2 [0:N2-1];
  logic signed [31:0] b3 [0:N3-1];
  logic signed [31:0] b4 [0:N4-1];
  logit_t neuralnet_out [0:N4-1];
`ifdef NN_DONE_OUT_EN
  logic nn_done;
`endif

  neural_network_param dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .neuralnet_out(neuralnet_out)
`ifdef NN_DONE_OUT_EN
    , .nn_done(nn_done)
`endif
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;
  logit_t exp_out [0:N4-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, $signed(act), $signed(req));
  endtask

  function automatic logic signed [127:0] wrap(input logic signed [127:0] v, input int bits);
    logic signed [127:0] t;
    t = v <<< (128 - bits);
    return t >>> (128 - bits);
  endfunction

  function automatic logic signed [127:0] relu(input logic signed [127:0] v);
    return (v < 0) ? 128'sd0 : v;
  endfunction

  function automatic int argmax(input logit_t v [0:N4-1]);
    int best = 0;
    for (int n = 1; n < N4; n++) if (v[n] > v[best]) best = n;
    return best;
  endfunction

  // Reference: dot products over the live entries only, with wrap to each layer width.
  task automatic run_model();
    logic signed [127:0] a1 [0:N1-1];
    logic signed [127:0] a2 [0:N2-1];
    logic signed [127:0] a3 [0:N3-1];
    logic signed [127:0] acc, xv, wv;
    for (int n = 0; n < N1; n++) begin
      acc = '0;
      for (int k = 0; k < 784; k++) begin
        xv = data_in[PADN+k]; wv = w1[n][PADN+k];
        acc += (xv * wv) >>> 16;
      end
      a1[n] = relu(wrap(acc + b1[n], 32));
    end
    for (int n = 0; n < N2; n++) begin
      acc = '0;
      for (int k = 0; k < N1; k++) begin
        wv = w2[n][PADN+k];
        acc += (a1[k] * wv) >>> 16;
      end
      a2[n] = relu(wrap(acc + b2[n], 40));
    end
    for (int n = 0; n < N3; n++) begin
      acc = '0;
      for (int k = 0; k < N2; k++) begin
        wv = w3[n][PADN+k];
        acc += (a2[k] * wv) >>> 16;
      end
      a3[n] = relu(wrap(acc + b3[n], 48));
    end
    for (int n = 0; n < N4; n++) begin
      acc = '0;
      for (int k = 0; k < N3; k++) begin
        wv = w4[n][PADN+k];
        acc += (a3[k] * wv) >>> 16;
      end
      exp_out[n] = 64'(wrap(acc + b4[n], 56));
    end
  endtask

  // Per-cycle compare against the latency schedule and the model's logits.
  logic [3:0] d_exp, d_act;
  int bad_idx;
  logit_t want;
  always @(negedge clk) begin
    if (chk_en) begin
      d_exp = {cyc >= T4, cyc >= T3, cyc >= T2, cyc >= T1};
      d_act = {dut.layer4_done, dut.layer3_done, dut.layer2_done, dut.layer1_done};
      check($sformatf("done_flags@%0d", cyc), 64'(d_act), 64'(d_exp));
`ifdef NN_DONE_OUT_EN
      check($sformatf("nn_done@%0d", cyc), 64'(nn_done), 64'(d_exp[3]));
`endif
      bad_idx = 0;
      for (int n = N4 - 1; n >= 0; n--) begin
        want = d_exp[3] ? exp_out[n] : 64'sd0;
        if (neuralnet_out[n] !== want) bad_idx = n;
      end
      want = d_exp[3] ? exp_out[bad_idx] : 64'sd0;
      check($sformatf("logit%0d@%0d", bad_idx, cyc), neuralnet_out[bad_idx], want);
    end
  end

  task automatic clear_all();
    for (int i = 0; i <= W1; i++) data_in[i] = '0;
    for (int n = 0; n < N1; n++) begin b1[n] = '0; for (int i = 0; i <= W1; i++) w1[n][i] = '0; end
    for (int n = 0; n < N2; n++) begin b2[n] = '0; for (int i = 0; i <= W2; i++) w2[n][i] = '0; end
    for (int n = 0; n < N3; n++) begin b3[n] = '0; for (int i = 0; i <= W3; i++) w3[n][i] = '0; end
    for (int n = 0; n < N4; n++) begin b4[n] = '0; for (int i = 0; i <= W4; i++) w4[n][i] = '0; end
  endtask

  function automatic logic signed [31:0] rnd(input bit full, input int span);
    if (full) return $urandom;
    return int'($urandom_range(0, 2 * span)) - span;
  endfunction

  // Pads are randomised too, so the masking is exercised.
  task automatic rand_fill(input bit full);
    for (int i = 0; i <= W1; i++)
      data_in[i] = full ? $urandom : int'($urandom_range(0, 65536));
    for (int n = 0; n < N1; n++) begin b1[n] = rnd(full, 6553); for (int i = 0; i <= W1; i++) w1[n][i] = rnd(full, 3276); end
    for (int n = 0; n < N2; n++) begin b2[n] = rnd(full, 6553); for (int i = 0; i <= W2; i++) w2[n][i] = rnd(full, 13107); end
    for (int n = 0; n < N3; n++) begin b3[n] = rnd(full, 6553); for (int i = 0; i <= W3; i++) w3[n][i] = rnd(full, 13107); end
    for (int n = 0; n < N4; n++) begin b4[n] = rnd(full, 6553); for (int i = 0; i <= W4; i++) w4[n][i] = rnd(full, 13107); end
  endtask

  task automatic start_run();
    chk_en = 1'b0;
    rst = 1'b1;
    run_model();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic finish_run(input string nm);
    repeat (T4 + 6) @(negedge clk);
    chk_en = 1'b0;
    $display("run %s: argmax=%0d model_argmax=%0d logit3=%0d logit5=%0d", nm,
             argmax(neuralnet_out), argmax(exp_out), neuralnet_out[3], neuralnet_out[5]);
  endtask

  initial begin
    // Bias-only logit.
    clear_all();
    b4[3] = 32'sh0001_0000;
    start_run();
    check("model_bias_logit3", exp_out[3], 64'sd65536);
    finish_run("bias_only");
    check("bias_logit3", neuralnet_out[3], 64'sd65536);
    check("bias_argmax", 64'(argmax(neuralnet_out)), 64'd3);

    // Single path through all four layers.
    clear_all();
    data_in[20] = 32'sh0001_0000;
    w1[0][20] = 32'sh0002_0000;
    w2[0][20] = 32'sh0001_0000;
    w3[0][20] = 32'sh0001_0000;
    w4[5][20] = 32'sh0001_0000;
    start_run();
    check("model_path_logit5", exp_out[5], 64'sd131072);
    finish_run("single_path");
    check("path_logit5", neuralnet_out[5], 64'sd131072);
    check("path_logit0", neuralnet_out[0], 64'sd0);
    check("path_argmax", 64'(argmax(neuralnet_out)), 64'd5);

    // Negative layer-1 result clamps; pad-entry data must not leak in.
    w1[0][20] = 32'shFFFE_0000;
    data_in[5] = 32'sh0005_0000;
    w1[0][5] = 32'sh0001_0000;
    start_run();
    check("model_relu_logit5", exp_out[5], 64'sd0);
    finish_run("relu_clamp");
    check("relu_logit5", neuralnet_out[5], 64'sd0);
    check("relu_logit3", neuralnet_out[3], 64'sd0);

    // Small-range random network.
    rand_fill(1'b0);
    start_run();
    finish_run("rand_small");
    check("rand_small_argmax", 64'(argmax(neuralnet_out)), 64'(argmax(exp_out)));

    // Abort mid-layer-2, then a full rerun must match the model again.
    rand_fill(1'b0);
    start_run();
    repeat (900) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_done_flags", 64'({dut.layer3_done, dut.layer2_done, dut.layer1_done}), 64'd0);
    check("abort_logit0", neuralnet_out[0], 64'sd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    finish_run("abort_rerun");
    check("abort_rerun_argmax", 64'(argmax(neuralnet_out)), 64'(argmax(exp_out)));

    // Full-range random values force every accumulator to wrap.
    rand_fill(1'b1);
    start_run();
    finish_run("rand_wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
